// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU port, external port and memory side.
// slave  : the arbiter's view (takes requests, drives acks and memory).
// master : the requesters'/memory model's view.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_din;
  logic [DW-1:0] c_dout;
  logic          c_ack;

  logic          x_req;
  logic          x_we;
  logic [AW-1:0] x_adr;
  logic [DW-1:0] x_din;
  logic [DW-1:0] x_dout;
  logic          x_ack;

  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_din;
  logic          m_we;
  logic          m_cs;
  logic [DW-1:0] m_dout;

  modport slave (
    input  c_req, c_we, c_adr, c_din,
    output c_dout, c_ack,
    input  x_req, x_we, x_adr, x_din,
    output x_dout, x_ack,
    output m_adr, m_din, m_we, m_cs,
    input  m_dout
  );

  modport master (
    output c_req, c_we, c_adr, c_din,
    input  c_dout, c_ack,
    output x_req, x_we, x_adr, x_din,
    input  x_dout, x_ack,
    input  m_adr, m_din, m_we, m_cs,
    output m_dout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported main memory.
// Grants CPU or external port, holds the memory control word for MEM_LAT
// cycles, captures read data and pulses the owner's ack for one cycle.
// Optional feature: define ARB_RR_EN for round-robin tie breaking
// (default build: fixed CPU priority).
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_arbiter_if.slave bus,
  output logic         busy,
  output logic [1:0]   owner
);

  localparam int          LAT      = (MEM_LAT < 1) ? 1 : MEM_LAT;
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_CPU = 2'b01, OWN_EXT = 2'b10} owner_t;

  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_owner;
  owner_t        r_last;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_din;
  logic [DW-1:0] r_cdout;
  logic [DW-1:0] r_xdout;
  logic          w_grant_cpu;
  logic          w_grant_ext;
  logic          w_last_cycle;

  // Next state, arbitration and all combinational outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_cpu  = 1'b0;
    w_grant_ext  = 1'b0;
    w_last_cycle = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    case (r_state)
      S_IDLE: begin
        if (bus.c_req || bus.x_req) begin
`ifdef ARB_RR_EN
          if (bus.c_req && bus.x_req) w_grant_cpu = (r_last == OWN_EXT);
          else                        w_grant_cpu = bus.c_req;
`else
          w_grant_cpu = bus.c_req;
`endif
          w_grant_ext = !w_grant_cpu;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: if (r_cnt == 4'd0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    bus.m_adr  = r_adr;
    bus.m_din  = r_din;
    bus.m_cs   = (r_state == S_ACCESS);
    bus.m_we   = w_last_cycle && r_we;
    bus.c_ack  = (r_state == S_DONE) && (r_owner == OWN_CPU);
    bus.x_ack  = (r_state == S_DONE) && (r_owner == OWN_EXT);
    bus.c_dout = r_cdout;
    bus.x_dout = r_xdout;
    busy       = (r_state != S_IDLE);
    owner      = r_owner;
  end

  // State register; async reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant latch, latency counter, read capture and last-owner tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= OWN_NONE;
      r_last  <= OWN_EXT;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_din   <= '0;
      r_cdout <= '0;
      r_xdout <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_cpu) begin
            r_adr   <= bus.c_adr;
            r_din   <= bus.c_din;
            r_we    <= bus.c_we;
            r_owner <= OWN_CPU;
            r_cnt   <= CNT_INIT;
          end else if (w_grant_ext) begin
            r_adr   <= bus.x_adr;
            r_din   <= bus.x_din;
            r_we    <= bus.x_we;
            r_owner <= OWN_EXT;
            r_cnt   <= CNT_INIT;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) begin
              if (r_owner == OWN_CPU) r_cdout <= bus.m_dout;
              else                    r_xdout <= bus.m_dout;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_last  <= r_owner;
          r_owner <= OWN_NONE;
        end
        default: r_owner <= OWN_NONE;
      endcase
    end
  end

  // The last-owner record always names a real port.
  always_ff @(posedge clk) begin
    if (reset_n) assert (r_last != OWN_NONE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 3;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();
  logic       busy, busy2;
  logic [1:0] owner, owner2;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .owner(owner));
  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(0)) dut_min (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .busy(busy2), .owner(owner2));

  // Memory model: unwritten locations return a fixed pattern.
  function automatic logic [15:0] pat(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {a, ~a};
  endfunction

  logic [15:0] mem [256];
  bit          written [256];
  always @(posedge clk) begin
    if (bus.m_we && bus.m_cs) begin
      mem[bus.m_adr]     <= bus.m_din;
      written[bus.m_adr] <= 1'b1;
    end
  end
  assign bus.m_dout  = written[bus.m_adr] ? mem[bus.m_adr] : pat(bus.m_adr);
  assign bus2.m_dout = pat(bus2.m_adr);

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int port; logic [15:0] data; int unsigned cyc; } obs_t;
  typedef struct { logic [7:0] adr; logic [15:0] data; int unsigned cyc; } wr_t;
  typedef struct { int port; bit we; logic [7:0] adr; logic [15:0] data; } exp_t;

  obs_t obsq[$];
  obs_t obs2q[$];
  wr_t  wq[$];
  exp_t expq[$];

  logic [15:0] shadow [int];
  logic [15:0] m_cdout = '0;
  logic [15:0] m_xdout = '0;
  int          m_last  = 2;
  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] exp_rd(input logic [7:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return pat(a);
  endfunction

  // Advance to the next falling edge and record acks and write strobes.
  task automatic tick();
    @(negedge clk);
    if (bus.c_ack && bus.x_ack) obsq.push_back('{3, 16'h0, cyc});
    else if (bus.c_ack)         obsq.push_back('{1, bus.c_dout, cyc});
    else if (bus.x_ack)         obsq.push_back('{2, bus.x_dout, cyc});
    if (bus.m_we) wq.push_back('{bus.m_adr, bus.m_din, cyc});
    if (bus2.c_ack) obs2q.push_back('{1, bus2.c_dout, cyc});
  endtask

  task automatic wait_obs(input int unsigned max, output bit ok);
    for (int unsigned i = 0; i < max && obsq.size() == 0; i++) tick();
    ok = (obsq.size() != 0);
  endtask

  task automatic clear_q();
    obsq.delete(); obs2q.delete(); wq.delete(); expq.delete();
  endtask

  task automatic cpu_issue(input bit we, input logic [7:0] a, input logic [15:0] d);
    bus.c_req = 1'b1; bus.c_we = we; bus.c_adr = a; bus.c_din = d;
    expq.push_back('{1, we, a, we ? d : exp_rd(a)});
    if (we) shadow[int'(a)] = d;
  endtask

  task automatic ext_issue(input bit we, input logic [7:0] a, input logic [15:0] d);
    bus.x_req = 1'b1; bus.x_we = we; bus.x_adr = a; bus.x_din = d;
    expq.push_back('{2, we, a, we ? d : exp_rd(a)});
    if (we) shadow[int'(a)] = d;
  endtask

  task automatic test_reset();
    tick();
    tests++;
    if ({bus.c_dout, bus.x_dout} !== 32'h0) begin
      fails++; $display("FAIL reset_dout: got %h/%h want 0/0", bus.c_dout, bus.x_dout);
    end
    tests++;
    if ({bus.m_adr, bus.m_din} !== 24'h0) begin
      fails++; $display("FAIL reset_mbus: got adr %h din %h want 0", bus.m_adr, bus.m_din);
    end
    tests++;
    if ({bus.m_we, bus.m_cs, bus.c_ack, bus.x_ack, busy, owner} !== 7'h0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0", {bus.m_we, bus.m_cs, bus.c_ack, bus.x_ack, busy, owner});
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_lat_min();
    int unsigned t0;
    clear_q();
    t0 = cyc;
    bus2.c_req = 1'b1; bus2.c_we = 1'b0; bus2.c_adr = 8'h10;
    for (int i = 0; i < 10 && obs2q.size() == 0; i++) tick();
    bus2.c_req = 1'b0;
    tests++;
    if (obs2q.size() == 0) begin
      fails++; $display("FAIL lat_min_ack: got no ack want ack in cycle 2");
    end else begin
      tests++;
      if (int'(obs2q[0].cyc - t0) !== 2) begin
        fails++; $display("FAIL lat_min_cycle: got %0d want 2", obs2q[0].cyc - t0);
      end
      tests++;
      if (obs2q[0].data !== 16'hBEEF) begin
        fails++; $display("FAIL lat_min_data: got %h want beef", obs2q[0].data);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_cpu_read();
    int unsigned t0; bit ok; obs_t o; exp_t e;
    clear_q();
    t0 = cyc;
    cpu_issue(1'b0, 8'h10, 16'h0);
    wait_obs(LAT + 8, ok);
    bus.c_req = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL cpu_read_ack: got none want ack");
    end else begin
      o = obsq.pop_front(); e = expq.pop_front();
      tests++;
      if (o.port !== e.port) begin fails++; $display("FAIL cpu_read_port: got %0d want %0d", o.port, e.port); end
      tests++;
      if (int'(o.cyc - t0) !== LAT + 1) begin fails++; $display("FAIL cpu_read_cycle: got %0d want %0d", o.cyc - t0, LAT + 1); end
      tests++;
      if (o.data !== e.data) begin fails++; $display("FAIL cpu_read_data: got %h want %h", o.data, e.data); end
      m_cdout = e.data; m_last = 1;
    end
    repeat (2) tick();
    tests++;
    if (wq.size() != 0) begin fails++; $display("FAIL cpu_read_no_we: got %0d strobes want 0", wq.size()); end
    tests++;
    if (bus.c_dout !== m_cdout) begin fails++; $display("FAIL cpu_read_hold: got %h want %h", bus.c_dout, m_cdout); end
  endtask

  task automatic test_ext_write();
    int unsigned t0; bit ok; obs_t o; exp_t e;
    clear_q();
    t0 = cyc;
    ext_issue(1'b1, 8'h20, 16'h1234);
    wait_obs(LAT + 8, ok);
    bus.x_req = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL ext_write_ack: got none want ack");
    end else begin
      o = obsq.pop_front(); e = expq.pop_front();
      tests++;
      if (o.port !== 2 || int'(o.cyc - t0) !== LAT + 1) begin
        fails++; $display("FAIL ext_write_ack_timing: got port %0d cycle %0d want port 2 cycle %0d", o.port, o.cyc - t0, LAT + 1);
      end
      tests++;
      if (o.data !== m_xdout) begin fails++; $display("FAIL ext_write_dout: got %h want %h", o.data, m_xdout); end
      m_last = 2;
    end
    repeat (2) tick();
    tests++;
    if (wq.size() != 1) begin
      fails++; $display("FAIL ext_write_strobes: got %0d want 1", wq.size());
    end else begin
      tests++;
      if (wq[0].adr !== 8'h20 || wq[0].data !== 16'h1234 || int'(wq[0].cyc - t0) !== LAT) begin
        fails++; $display("FAIL ext_write_strobe: got adr %h din %h cycle %0d want 20 1234 %0d", wq[0].adr, wq[0].data, wq[0].cyc - t0, LAT);
      end
    end
  endtask

  task automatic test_arbitration();
    int lastsim; int win; bit ok; obs_t o; exp_t e; int unsigned prev;
    clear_q();
    lastsim = m_last;
    for (int k = 0; k < 4; k++) begin
      win = RR ? ((lastsim == 2) ? 1 : 2) : 1;
      expq.push_back('{win, 1'b0, (win == 1) ? 8'h30 : 8'h31, exp_rd((win == 1) ? 8'h30 : 8'h31)});
      lastsim = win;
    end
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_adr = 8'h30;
    bus.x_req = 1'b1; bus.x_we = 1'b0; bus.x_adr = 8'h31;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_obs(2 * (LAT + 2) + 4, ok);
      tests++;
      if (!ok) begin
        fails++; $display("FAIL arb_ack%0d: got none want ack", k);
        break;
      end
      o = obsq.pop_front(); e = expq.pop_front();
      tests++;
      if (o.port !== e.port) begin fails++; $display("FAIL arb_owner%0d: got %0d want %0d", k, o.port, e.port); end
      tests++;
      if (o.data !== e.data) begin fails++; $display("FAIL arb_data%0d: got %h want %h", k, o.data, e.data); end
      if (k > 0) begin
        tests++;
        if (int'(o.cyc - prev) !== LAT + 2) begin fails++; $display("FAIL arb_spacing%0d: got %0d want %0d", k, o.cyc - prev, LAT + 2); end
      end
      prev = o.cyc; m_last = e.port;
      if (e.port == 1) m_cdout = e.data; else m_xdout = e.data;
    end
    bus.c_req = 1'b0; bus.x_req = 1'b0;
    repeat (LAT + 4) tick();
    tests++;
    if (obsq.size() != 0) begin fails++; $display("FAIL arb_dropped: got %0d extra acks want 0", obsq.size()); end
  endtask

  task automatic test_wait_during_access();
    int unsigned t0; bit ok; obs_t o; exp_t e; int unsigned tc;
    clear_q();
    t0 = cyc; tc = 0;
    cpu_issue(1'b0, 8'h40, 16'h0);
    repeat (2) tick();
    ext_issue(1'b0, 8'h41, 16'h0);
    wait_obs(LAT + 8, ok);
    bus.c_req = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL wait_c_ack: got none want ack");
    end else begin
      o = obsq.pop_front(); e = expq.pop_front(); tc = o.cyc;
      tests++;
      if (o.port !== 1 || int'(o.cyc - t0) !== LAT + 1 || o.data !== e.data) begin
        fails++; $display("FAIL wait_c: got port %0d cycle %0d data %h want 1 %0d %h", o.port, o.cyc - t0, o.data, LAT + 1, e.data);
      end
      m_cdout = e.data; m_last = 1;
    end
    wait_obs(2 * (LAT + 2) + 4, ok);
    bus.x_req = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL wait_x_ack: got none want ack");
    end else begin
      o = obsq.pop_front(); e = expq.pop_front();
      tests++;
      if (o.port !== 2 || int'(o.cyc - tc) !== LAT + 2 || o.data !== e.data) begin
        fails++; $display("FAIL wait_x: got port %0d gap %0d data %h want 2 %0d %h", o.port, o.cyc - tc, o.data, LAT + 2, e.data);
      end
      m_xdout = e.data; m_last = 2;
    end
    tick();
    tests++;
    if (bus.c_dout !== m_cdout) begin fails++; $display("FAIL wait_c_dout_hold: got %h want %h", bus.c_dout, m_cdout); end
  endtask

  task automatic test_drop_before_grant();
    bit ok; obs_t o;
    clear_q();
    cpu_issue(1'b0, 8'h42, 16'h0);
    repeat (2) tick();
    bus.x_req = 1'b1; bus.x_we = 1'b0; bus.x_adr = 8'h43;
    tick();
    bus.x_req = 1'b0;
    wait_obs(LAT + 8, ok);
    bus.c_req = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL drop_c_ack: got none want ack");
    end else begin
      o = obsq.pop_front();
      m_cdout = expq[0].data; m_last = 1;
      tests++;
      if (o.port !== 1) begin fails++; $display("FAIL drop_c_port: got %0d want 1", o.port); end
    end
    repeat (LAT + 4) tick();
    tests++;
    if (obsq.size() != 0) begin fails++; $display("FAIL drop_no_x_ack: got %0d acks want 0", obsq.size()); end
  endtask

  task automatic test_input_change();
    bit ok; obs_t o;
    clear_q();
    cpu_issue(1'b1, 8'h60, 16'h6060);
    tick();
    bus.c_adr = 8'h61; bus.c_din = 16'hFFFF;
    wait_obs(LAT + 8, ok);
    bus.c_req = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL chg_ack: got none want ack");
    end else begin
      o = obsq.pop_front(); m_last = 1;
      tests++;
      if (o.port !== 1 || o.data !== m_cdout) begin
        fails++; $display("FAIL chg_ack_port_dout: got %0d %h want 1 %h", o.port, o.data, m_cdout);
      end
    end
    tests++;
    if (wq.size() != 1 || wq[0].adr !== 8'h60 || wq[0].data !== 16'h6060) begin
      fails++; $display("FAIL chg_latched: got %0d strobes adr %h din %h want 1 60 6060", wq.size(),
                        (wq.size() > 0) ? wq[0].adr : 8'h0, (wq.size() > 0) ? wq[0].data : 16'h0);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_abort();
    bit ok; obs_t o; exp_t e;
    clear_q();
    bus.x_req = 1'b1; bus.x_we = 1'b1; bus.x_adr = 8'h50; bus.x_din = 16'h9999;
    repeat (LAT) tick();
    tests++;
    if (bus.m_we !== 1'b1) begin fails++; $display("FAIL abort_pre_we: got %b want 1", bus.m_we); end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({bus.m_we, bus.m_cs, bus.c_ack, bus.x_ack, busy, owner} !== 7'h0) begin
      fails++; $display("FAIL abort_async: got %b want 0", {bus.m_we, bus.m_cs, bus.c_ack, bus.x_ack, busy, owner});
    end
    tests++;
    if ({bus.c_dout, bus.x_dout} !== 32'h0) begin fails++; $display("FAIL abort_dout: got %h/%h want 0", bus.c_dout, bus.x_dout); end
    bus.x_req = 1'b0;
    m_cdout = '0; m_xdout = '0; m_last = 2;
    tick();
    reset_n = 1'b1;
    clear_q();
    repeat (LAT + 4) tick();
    tests++;
    if (obsq.size() != 0 || wq.size() != 0) begin
      fails++; $display("FAIL abort_quiet: got %0d acks %0d strobes want 0 0", obsq.size(), wq.size());
    end
    ext_issue(1'b1, 8'h50, 16'h9999);
    wait_obs(LAT + 8, ok);
    bus.x_req = 1'b0;
    tests++;
    if (!ok || wq.size() != 1 || wq[0].data !== 16'h9999) begin
      fails++; $display("FAIL abort_reissue: got ack %b strobes %0d want 1 1", ok, wq.size());
    end
    if (ok) begin o = obsq.pop_front(); e = expq.pop_front(); m_last = 2; end
    repeat (2) tick();
    cpu_issue(1'b0, 8'h50, 16'h0);
    wait_obs(LAT + 8, ok);
    bus.c_req = 1'b0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL abort_readback_ack: got none want ack");
    end else begin
      o = obsq.pop_front(); e = expq.pop_front();
      tests++;
      if (o.data !== e.data) begin fails++; $display("FAIL abort_readback: got %h want %h", o.data, e.data); end
    end
    repeat (2) tick();
  endtask

  initial begin
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_adr = '0; bus.c_din = '0;
    bus.x_req = 1'b0; bus.x_we = 1'b0; bus.x_adr = '0; bus.x_din = '0;
    bus2.c_req = 1'b0; bus2.c_we = 1'b0; bus2.c_adr = '0; bus2.c_din = '0;
    bus2.x_req = 1'b0; bus2.x_we = 1'b0; bus2.x_adr = '0; bus2.x_din = '0;
    test_reset();
    test_lat_min();
    test_cpu_read();
    test_ext_write();
    test_arbitration();
    test_wait_during_access();
    test_drop_before_grant();
    test_input_change();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
